// File: rtl/mt9v034_multi_sync_decoder.sv
// mt9v034_multi_sync_decoder
// N-channel embedded-sync decoder for MT9V034 imagers. Each lane is searched
// for the FF/00/00/<code> sync sequence. Recognised sequences are blanked out of
// the video stream, and each lane gets its own active/hblank/vblank timing.
// Line and frame lengths are checked, and a flag reports whether all lanes
// started their last line on the same beat.
// Optional build macro: MT9V034_SYNC_ERR_CNT_EN adds clr_err_cnt and
// sync_err_cnt (per-lane 16-bit saturating sync error counters).
module mt9v034_multi_sync_decoder #(
  parameter int NUM_CHANNELS    = 2,
  parameter int VIDEO_BIT_WIDTH = 8,
  parameter int H_ACTIVE        = 752,
  parameter int V_ACTIVE        = 480
) (
  input  logic                                    pxclk,
  input  logic                                    aresetn,
  input  logic                                    in_valid,
  input  logic [NUM_CHANNELS*VIDEO_BIT_WIDTH-1:0] in_data,
  output logic                                    out_valid,
  output logic [NUM_CHANNELS*VIDEO_BIT_WIDTH-1:0] vid_data,
  output logic [NUM_CHANNELS-1:0]                 vid_active_video,
  output logic [NUM_CHANNELS-1:0]                 vid_hblank,
  output logic [NUM_CHANNELS-1:0]                 vid_vblank,
  output logic [NUM_CHANNELS-1:0]                 line_err,
  output logic [NUM_CHANNELS-1:0]                 frame_err,
  output logic                                    channels_aligned
`ifdef MT9V034_SYNC_ERR_CNT_EN
  ,
  input  logic                                    clr_err_cnt,
  output logic [NUM_CHANNELS*16-1:0]              sync_err_cnt
`endif
);

  localparam int W = VIDEO_BIT_WIDTH;

  // Preamble tracker states
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // Video timing states
  localparam logic [1:0] ST_VBLANK = 2'd0;
  localparam logic [1:0] ST_HBLANK = 2'd1;
  localparam logic [1:0] ST_LINE   = 2'd2;

  // Code words sit in the upper 8 bits; extra low bits must be zero
  localparam logic [W-1:0] ONES_W = {W{1'b1}};
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] SOF_W  = W'(8'hAB) << (W - 8);
  localparam logic [W-1:0] SOL_W  = W'(8'h80) << (W - 8);
  localparam logic [W-1:0] EOL_W  = W'(8'h9D) << (W - 8);
  localparam logic [W-1:0] EOF_W  = W'(8'hB6) << (W - 8);

  localparam logic [15:0] H_ACTIVE_C = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACTIVE_C = 16'(V_ACTIVE);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  // Per-lane "line start" decode (SOL or SOF), feeds the alignment flag
  logic [NUM_CHANNELS-1:0] line_start_s;

  genvar c;
  for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [W-1:0]      word_s;
    logic [1:0]        pre_st_r;
    logic [1:0]        pre_nxt_s;
    logic [1:0]        tim_st_r;
    logic [1:0]        tim_nxt_s;
    logic [3:0][W-1:0] dly_r;
    logic [3:0]        mask_r;
    logic [3:0]        eol_tag_r;
    logic [3:0]        eof_tag_r;
    logic [15:0]       pix_cnt_r;
    logic [15:0]       line_cnt_r;
    logic [W-1:0]      data_out_r;
    logic              active_r;
    logic              hblank_r;
    logic              vblank_r;
    logic              line_err_r;
    logic              frame_err_r;
    logic              at_code_s;
    logic              is_sof_s;
    logic              is_sol_s;
    logic              is_eol_s;
    logic              is_eof_s;
    logic              code_ok_s;
    logic              code_bad_s;
    logic              sol_take_s;
    logic              eol_take_s;
    logic              eof_take_s;
    logic              emit_active_s;
    logic              le_next_s;
    logic              fe_next_s;

    assign word_s = in_data[c*W +: W];

    // Code decode happens only on an accepted beat in P3
    assign at_code_s  = in_valid && (pre_st_r == P3);
    assign is_sof_s   = at_code_s && (word_s == SOF_W);
    assign is_sol_s   = at_code_s && (word_s == SOL_W);
    assign is_eol_s   = at_code_s && (word_s == EOL_W);
    assign is_eof_s   = at_code_s && (word_s == EOF_W);
    assign code_ok_s  = is_sof_s | is_sol_s | is_eol_s | is_eof_s;
    assign code_bad_s = at_code_s && !code_ok_s;

    assign line_start_s[c] = is_sof_s | is_sol_s;

    // The word leaving the delay line uses the timing state in force now;
    // any sync sequence still inside the line is masked, so this is exact
    assign emit_active_s = in_valid && !mask_r[3] && (tim_st_r == ST_LINE);
    assign le_next_s     = in_valid && eol_tag_r[3] && (pix_cnt_r != H_ACTIVE_C);
    assign fe_next_s     = in_valid && eof_tag_r[3] && (line_cnt_r != V_ACTIVE_C);

    // Preamble tracker next state: FF, 00, 00, then the code word
    always_comb begin
      pre_nxt_s = P0;
      case (pre_st_r)
        P0: begin
          if (word_s == ONES_W) pre_nxt_s = P1;
          else                  pre_nxt_s = P0;
        end
        P1: begin
          if (word_s == ZERO_W)      pre_nxt_s = P2;
          else if (word_s == ONES_W) pre_nxt_s = P1;
          else                       pre_nxt_s = P0;
        end
        P2: begin
          if (word_s == ZERO_W)      pre_nxt_s = P3;
          else if (word_s == ONES_W) pre_nxt_s = P1;
          else                       pre_nxt_s = P0;
        end
        P3:      pre_nxt_s = P0;
        default: pre_nxt_s = P0;
      endcase
    end

    // Timing next state; SOF restarts the frame from any state
    always_comb begin
      tim_nxt_s  = tim_st_r;
      sol_take_s = 1'b0;
      eol_take_s = 1'b0;
      eof_take_s = 1'b0;
      if (is_sof_s) begin
        tim_nxt_s = ST_LINE;
      end else begin
        case (tim_st_r)
          ST_LINE: begin
            if (is_eol_s) begin
              tim_nxt_s  = ST_HBLANK;
              eol_take_s = 1'b1;
            end else begin
              tim_nxt_s = ST_LINE;
            end
          end
          ST_HBLANK: begin
            if (is_sol_s) begin
              tim_nxt_s  = ST_LINE;
              sol_take_s = 1'b1;
            end else if (is_eof_s) begin
              tim_nxt_s  = ST_VBLANK;
              eof_take_s = 1'b1;
            end else begin
              tim_nxt_s = ST_HBLANK;
            end
          end
          ST_VBLANK: tim_nxt_s = ST_VBLANK;
          default:   tim_nxt_s = ST_VBLANK;
        endcase
      end
    end

    // Lane state, delay line, counters and registered video outputs
    always_ff @(posedge pxclk or negedge aresetn) begin
      if (!aresetn) begin
        pre_st_r    <= P0;
        tim_st_r    <= ST_VBLANK;
        dly_r       <= '0;
        mask_r      <= 4'b0000;
        eol_tag_r   <= 4'b0000;
        eof_tag_r   <= 4'b0000;
        pix_cnt_r   <= 16'h0000;
        line_cnt_r  <= 16'h0000;
        data_out_r  <= ZERO_W;
        active_r    <= 1'b0;
        hblank_r    <= 1'b1;
        vblank_r    <= 1'b1;
        line_err_r  <= 1'b0;
        frame_err_r <= 1'b0;
      end else if (in_valid) begin
        pre_st_r  <= pre_nxt_s;
        tim_st_r  <= tim_nxt_s;
        dly_r     <= {dly_r[2:0], word_s};
        // A decoded code masks itself and the three preamble words behind it
        mask_r    <= {mask_r[2:0] | {3{code_ok_s}}, code_ok_s};
        eol_tag_r <= {eol_tag_r[2:0], eol_take_s};
        eof_tag_r <= {eof_tag_r[2:0], eof_take_s};

        data_out_r  <= mask_r[3] ? ZERO_W : dly_r[3];
        active_r    <= emit_active_s;
        hblank_r    <= mask_r[3] || (tim_st_r != ST_LINE);
        vblank_r    <= (tim_st_r == ST_VBLANK);
        line_err_r  <= le_next_s;
        frame_err_r <= fe_next_s;

        if (is_sof_s || sol_take_s)
          pix_cnt_r <= 16'h0000;
        else if (emit_active_s && (pix_cnt_r != CNT_MAX))
          pix_cnt_r <= pix_cnt_r + 16'd1;

        if (is_sof_s)
          line_cnt_r <= 16'h0000;
        else if (eol_take_s && (line_cnt_r != CNT_MAX))
          line_cnt_r <= line_cnt_r + 16'd1;
      end else begin
        // Idle beat: video holds, error pulses end
        line_err_r  <= 1'b0;
        frame_err_r <= 1'b0;
      end
    end

    assign vid_data[c*W +: W]  = data_out_r;
    assign vid_active_video[c] = active_r;
    assign vid_hblank[c]       = hblank_r;
    assign vid_vblank[c]       = vblank_r;
    assign line_err[c]         = line_err_r;
    assign frame_err[c]        = frame_err_r;

`ifdef MT9V034_SYNC_ERR_CNT_EN
    logic [15:0] err_cnt_r;

    // Saturating sync error counter; a clear beats a same-cycle increment
    always_ff @(posedge pxclk or negedge aresetn) begin
      if (!aresetn) begin
        err_cnt_r <= 16'h0000;
      end else if (clr_err_cnt) begin
        err_cnt_r <= 16'h0000;
      end else if ((le_next_s || fe_next_s || code_bad_s) && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end

    assign sync_err_cnt[c*16 +: 16] = err_cnt_r;
`endif
  end

  // Output beat strobe follows the accepted input beat
  always_ff @(posedge pxclk or negedge aresetn) begin
    if (!aresetn) out_valid <= 1'b0;
    else          out_valid <= in_valid;
  end

  // Lanes are aligned while their latest line starts landed on one beat
  always_ff @(posedge pxclk or negedge aresetn) begin
    if (!aresetn)               channels_aligned <= 1'b0;
    else if (&line_start_s)     channels_aligned <= 1'b1;
    else if (|line_start_s)     channels_aligned <= 1'b0;
  end

endmodule

// File: tb/tb_mt9v034_multi_sync_decoder.sv
// Directed bench for mt9v034_multi_sync_decoder (2 lanes x 8 bit, 752x480).
// Streams are built per lane in queues, driven beat by beat, and every output
// beat is captured for comparison with hand-derived expectations.
module tb_mt9v034_multi_sync_decoder;

  logic        pxclk = 1'b0;
  logic        aresetn;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] vid_data;
  logic [1:0]  vid_active_video;
  logic [1:0]  vid_hblank;
  logic [1:0]  vid_vblank;
  logic [1:0]  line_err;
  logic [1:0]  frame_err;
  logic        channels_aligned;
`ifdef MT9V034_SYNC_ERR_CNT_EN
  logic        clr_err_cnt;
  logic [31:0] sync_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int clr_at = -1;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  cd0[$];
  logic [7:0]  cd1[$];
  logic [1:0]  cact[$];
  logic [1:0]  chb[$];
  logic [1:0]  cvb[$];
  logic [1:0]  cle[$];
  logic [1:0]  cfe[$];
  logic        cal[$];
  int          idle_idx[$];
  logic [15:0] idle_data[$];
  logic [1:0]  idle_act[$];

  mt9v034_multi_sync_decoder #(
    .NUM_CHANNELS(2), .VIDEO_BIT_WIDTH(8), .H_ACTIVE(752), .V_ACTIVE(480)
  ) dut (
    .pxclk(pxclk), .aresetn(aresetn), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .vid_data(vid_data), .vid_active_video(vid_active_video),
    .vid_hblank(vid_hblank), .vid_vblank(vid_vblank), .line_err(line_err),
    .frame_err(frame_err), .channels_aligned(channels_aligned)
`ifdef MT9V034_SYNC_ERR_CNT_EN
    , .clr_err_cnt(clr_err_cnt), .sync_err_cnt(sync_err_cnt)
`endif
  );

  always #5 pxclk = ~pxclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line layout: capture i carries input word i-4; SOF at words 0..3,
  // pixels 0x10+n at words 4..755, EOL at 756..759, flush zeros after.
  function automatic logic [7:0] exp_pix(input int i);
    if (i >= 8 && i < 760) return 8'(i + 8);
    else                   return 8'h00;
  endfunction

  function automatic logic exp_act(input int i);
    return (i >= 8 && i < 760);
  endfunction

  task automatic push_w(input logic [7:0] a0, input logic [7:0] a1);
    q0.push_back(a0);
    q1.push_back(a1);
  endtask

  task automatic push_sync(input logic [7:0] code);
    push_w(8'hFF, 8'hFF); push_w(8'h00, 8'h00); push_w(8'h00, 8'h00); push_w(code, code);
  endtask

  task automatic push_flush();
    for (int i = 0; i < 4; i++) push_w(8'h00, 8'h00);
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete();
  endtask

  task automatic record_beat();
    if (out_valid === 1'b1) begin
      cd0.push_back(vid_data[7:0]);
      cd1.push_back(vid_data[15:8]);
      cact.push_back(vid_active_video);
      chb.push_back(vid_hblank);
      cvb.push_back(vid_vblank);
      cle.push_back(line_err);
      cfe.push_back(frame_err);
      cal.push_back(channels_aligned);
    end else if (cd0.size() > 0) begin
      idle_idx.push_back(cd0.size() - 1);
      idle_data.push_back(vid_data);
      idle_act.push_back(vid_active_video);
    end
  endtask

  // Drive the queued words; with toggle set, an idle beat of FF precedes each word
  task automatic run_stream(input bit toggle);
    cd0.delete(); cd1.delete(); cact.delete(); chb.delete(); cvb.delete();
    cle.delete(); cfe.delete(); cal.delete();
    idle_idx.delete(); idle_data.delete(); idle_act.delete();
    for (int i = 0; i < q0.size(); i++) begin
      if (toggle) begin
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        @(posedge pxclk); #1;
        record_beat();
      end
      in_valid = 1'b1;
      in_data  = {q1[i], q0[i]};
`ifdef MT9V034_SYNC_ERR_CNT_EN
      clr_err_cnt = (i == clr_at);
`endif
      @(posedge pxclk); #1;
      record_beat();
    end
    in_valid = 1'b0;
    in_data  = 16'h0000;
`ifdef MT9V034_SYNC_ERR_CNT_EN
    clr_err_cnt = 1'b0;
`endif
  endtask

  task automatic build_line();
    clear_q();
    push_sync(8'hAB);
    for (int i = 0; i < 752; i++) push_w(8'(16 + i), 8'(16 + i));
    push_sync(8'h9D);
    push_flush();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    repeat (3) @(posedge pxclk);
    #1;
    checks++; if (vid_hblank !== 2'b11) begin errors++; $display("FAIL reset_hblank: got %b expected 11", vid_hblank); end
    checks++; if (vid_vblank !== 2'b11) begin errors++; $display("FAIL reset_vblank: got %b expected 11", vid_vblank); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({vid_data, vid_active_video, line_err, frame_err, channels_aligned} !== 23'd0) begin
      errors++; $display("FAIL reset_zero_outputs: data=%h act=%b le=%b fe=%b al=%b expected all 0",
                         vid_data, vid_active_video, line_err, frame_err, channels_aligned); end
    @(negedge pxclk) aresetn = 1'b1;
    @(posedge pxclk); #1;
    // Start a line, then reset in the middle of it
    clear_q();
    push_sync(8'hAB);
    for (int i = 0; i < 8; i++) push_w(8'(16 + i), 8'(16 + i));
    run_stream(1'b0);
    checks++; if (vid_active_video !== 2'b11) begin errors++; $display("FAIL midline_active: got %b expected 11", vid_active_video); end
    #3 aresetn = 1'b0;
    #1;
    checks++; if ({vid_hblank, vid_vblank} !== 4'b1111) begin
      errors++; $display("FAIL midreset_blank: hb=%b vb=%b expected 11 11", vid_hblank, vid_vblank); end
    checks++; if ({out_valid, vid_data, vid_active_video, channels_aligned} !== 20'd0) begin
      errors++; $display("FAIL midreset_zero: ov=%b data=%h act=%b al=%b expected all 0",
                         out_valid, vid_data, vid_active_video, channels_aligned); end
    @(negedge pxclk) aresetn = 1'b1;
    @(posedge pxclk); #1;
  endtask

  task automatic test_single_line();
    int n, bad, cnt0, cnt1, first0, first1, le_cnt;
    build_line();
    n = q0.size();
    run_stream(1'b0);
    checks++; if (cd0.size() !== n) begin errors++; $display("FAIL line_beats: got %0d expected %0d", cd0.size(), n); end
    bad = 0; cnt0 = 0; cnt1 = 0; first0 = -1; first1 = -1; le_cnt = 0;
    for (int i = 0; i < cd0.size(); i++) begin
      if (cact[i][0]) begin cnt0++; if (first0 < 0) first0 = i; end
      if (cact[i][1]) begin cnt1++; if (first1 < 0) first1 = i; end
      if (cle[i] !== 2'b00) le_cnt++;
      if (cd0[i] !== exp_pix(i) || cd1[i] !== exp_pix(i) || cact[i] !== {2{exp_act(i)}} ||
          chb[i] !== {2{~exp_act(i)}}) bad++;
    end
    checks++; if (cnt0 !== 752 || cnt1 !== 752) begin errors++; $display("FAIL line_active_count: got %0d/%0d expected 752/752", cnt0, cnt1); end
    checks++; if (first0 !== 8 || first1 !== 8) begin errors++; $display("FAIL line_first_pixel: got %0d/%0d expected 8/8", first0, first1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL line_data_mask: got %0d bad beats expected 0", bad); end
    checks++; if (le_cnt !== 0) begin errors++; $display("FAIL line_err_clean: got %0d pulses expected 0", le_cnt); end
    checks++; if (channels_aligned !== 1'b1) begin errors++; $display("FAIL line_aligned: got %b expected 1", channels_aligned); end
    checks++; if ({chb[n-1], cvb[n-1]} !== 4'b1100) begin
      errors++; $display("FAIL line_end_blank: hb=%b vb=%b expected 11 00", chb[n-1], cvb[n-1]); end
  endtask

  task automatic test_short_line();
    int le0, le1, cnt0, cnt1;
    clear_q();
    push_sync(8'h80);
    for (int i = 0; i < 752; i++) q0.push_back(8'(16 + i));
    for (int i = 0; i < 751; i++) q1.push_back(8'(16 + i));
    q0.push_back(8'hFF); q0.push_back(8'h00); q0.push_back(8'h00); q0.push_back(8'h9D);
    q1.push_back(8'hFF); q1.push_back(8'h00); q1.push_back(8'h00); q1.push_back(8'h9D);
    q1.push_back(8'h00);
    push_flush();
    run_stream(1'b0);
    le0 = 0; le1 = 0; cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < cle.size(); i++) begin
      if (cle[i][0]) le0++;
      if (cle[i][1]) le1++;
      if (cact[i][0]) cnt0++;
      if (cact[i][1]) cnt1++;
    end
    checks++; if (cle[762] !== 2'b10) begin errors++; $display("FAIL short_line_err: got %b expected 10", cle[762]); end
    checks++; if (le0 !== 0 || le1 !== 1) begin errors++; $display("FAIL short_line_pulses: got %0d/%0d expected 0/1", le0, le1); end
    checks++; if (cnt0 !== 752 || cnt1 !== 751) begin errors++; $display("FAIL short_line_count: got %0d/%0d expected 752/751", cnt0, cnt1); end
    checks++; if (channels_aligned !== 1'b1) begin errors++; $display("FAIL short_line_aligned: got %b expected 1", channels_aligned); end
  endtask

  task automatic test_skew();
    clear_q();
    push_w(8'hFF, 8'h11); push_w(8'h00, 8'hFF); push_w(8'h00, 8'h00);
    push_w(8'h80, 8'h00); push_w(8'h11, 8'h80); push_w(8'h11, 8'h11);
    push_flush();
    run_stream(1'b0);
    checks++; if (channels_aligned !== 1'b0) begin errors++; $display("FAIL skew_aligned: got %b expected 0", channels_aligned); end
    checks++; if (cact[8] !== 2'b01 || cact[9] !== 2'b11) begin
      errors++; $display("FAIL skew_active: got %b %b expected 01 11", cact[8], cact[9]); end
  endtask

  task automatic test_frame();
    int fe0, fe1, n;
    for (int f = 0; f < 2; f++) begin
      clear_q();
      push_sync(8'hAB);
      push_sync(8'h9D);
      for (int l = 1; l < 480 - f; l++) begin push_sync(8'h80); push_sync(8'h9D); end
      push_sync(8'hB6);
      push_flush();
      n = q0.size();
      run_stream(1'b0);
      fe0 = 0; fe1 = 0;
      for (int i = 0; i < cfe.size(); i++) begin
        if (cfe[i][0]) fe0++;
        if (cfe[i][1]) fe1++;
      end
      if (f == 0) begin
        checks++; if (fe0 !== 0 || fe1 !== 0) begin errors++; $display("FAIL frame480_err: got %0d/%0d expected 0/0", fe0, fe1); end
      end else begin
        checks++; if (cfe[n-1] !== 2'b11) begin errors++; $display("FAIL frame479_err: got %b expected 11", cfe[n-1]); end
        checks++; if (fe0 !== 1 || fe1 !== 1) begin errors++; $display("FAIL frame479_pulses: got %0d/%0d expected 1/1", fe0, fe1); end
      end
      checks++; if (cvb[n-1] !== 2'b11 || vid_vblank !== 2'b11) begin
        errors++; $display("FAIL frame%0d_vblank: got %b/%b expected 11/11", f, cvb[n-1], vid_vblank); end
    end
  endtask

  task automatic test_back_to_back();
    int n, bad, hold_bad, cnt0, cnt1, first0, first1;
    build_line();
    n = q0.size();
    run_stream(1'b1);
    checks++; if (cd0.size() !== n) begin errors++; $display("FAIL toggle_beats: got %0d expected %0d", cd0.size(), n); end
    bad = 0; cnt0 = 0; cnt1 = 0; first0 = -1; first1 = -1;
    for (int i = 0; i < cd0.size(); i++) begin
      if (cact[i][0]) begin cnt0++; if (first0 < 0) first0 = i; end
      if (cact[i][1]) begin cnt1++; if (first1 < 0) first1 = i; end
      if (cd0[i] !== exp_pix(i) || cd1[i] !== exp_pix(i) || cact[i] !== {2{exp_act(i)}}) bad++;
    end
    checks++; if (cnt0 !== 752 || cnt1 !== 752 || first0 !== 8 || first1 !== 8) begin
      errors++; $display("FAIL toggle_count_latency: got %0d/%0d first %0d/%0d expected 752/752 first 8/8",
                         cnt0, cnt1, first0, first1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_order: got %0d bad beats expected 0", bad); end
    hold_bad = 0;
    for (int j = 0; j < idle_idx.size(); j++) begin
      if (idle_data[j] !== {exp_pix(idle_idx[j]), exp_pix(idle_idx[j])} ||
          idle_act[j] !== {2{exp_act(idle_idx[j])}}) hold_bad++;
    end
    checks++; if (idle_idx.size() !== n - 1 || hold_bad !== 0) begin
      errors++; $display("FAIL toggle_hold: got %0d idle beats %0d bad expected %0d idle 0 bad",
                         idle_idx.size(), hold_bad, n - 1); end
  endtask

`ifdef MT9V034_SYNC_ERR_CNT_EN
  task automatic test_err_cnt();
    clr_err_cnt = 1'b1;
    @(posedge pxclk); #1;
    clr_err_cnt = 1'b0;
    checks++; if (sync_err_cnt !== 32'd0) begin errors++; $display("FAIL errcnt_clear: got %h expected 0", sync_err_cnt); end
    clear_q();
    push_w(8'hFF, 8'h00); push_w(8'h00, 8'h00); push_w(8'h00, 8'h00); push_w(8'h55, 8'h00);
    push_flush();
    run_stream(1'b0);
    checks++; if (sync_err_cnt !== 32'h0000_0001) begin errors++; $display("FAIL errcnt_bad_code: got %h expected 00000001", sync_err_cnt); end
    clear_q();
    push_sync(8'h80);
    for (int i = 0; i < 3; i++) push_w(8'(16 + i), 8'(16 + i));
    push_sync(8'h9D);
    push_flush();
    clr_at = 14;
    run_stream(1'b0);
    clr_at = -1;
    checks++; if (cle[14] !== 2'b11) begin errors++; $display("FAIL errcnt_le_seen: got %b expected 11", cle[14]); end
    checks++; if (sync_err_cnt !== 32'd0) begin errors++; $display("FAIL errcnt_clear_wins: got %h expected 0", sync_err_cnt); end
  endtask
`endif

  initial begin
`ifdef MT9V034_SYNC_ERR_CNT_EN
    clr_err_cnt = 1'b0;
`endif
    test_reset();
    test_single_line();
    test_short_line();
    test_skew();
    test_frame();
    test_back_to_back();
`ifdef MT9V034_SYNC_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
